// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-stream FIFO: pointer sizing and depth legality.
// Optional output register is selected with AXIS_FIFO_OUTPUT_REG_EN in axis_fifo.
package axis_pkg;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-stream channel: valid/ready/data of a parameterised word type.
// A word transfers on a rising edge where valid and ready are both high; once raised,
// valid holds (with data stable) until that transfer, and ready may wait on valid.
interface axis_if #(
  parameter type data_t = logic [7:0]
);
  logic  valid;
  logic  ready;
  data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset on contents.
module axis_fifo_mem #(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  data_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output data_t         rdata_o
);

  data_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// Single-clock AXI-stream FIFO with fill level. Define AXIS_FIFO_OUTPUT_REG_EN to add a
// registered output stage (latency 2, capacity DEPTH+1); default is async-read output.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter int  LEVEL_W = $clog2(DEPTH + 2),
  parameter type data_t  = logic [7:0]
) (
  input  logic               clk,
  input  logic               rst,
  axis_if.slave              in,
  axis_if.master             out,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (!(is_pow2(DEPTH) && DEPTH >= 2)) begin : g_depth_check
    $error("axis_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               mem_empty, mem_full;
  logic               accept, rel, mem_pop;
  data_t              rd_data;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in.ready  = ~mem_full & ~rst;
  assign accept    = in.valid & in.ready;

  axis_fifo_mem #(.data_t(data_t), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in.data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

`ifdef AXIS_FIFO_OUTPUT_REG_EN
  logic  ovalid_q, ovalid_d;
  data_t odata_q, odata_d;

  // Refill the output register whenever it is empty or being drained this cycle.
  assign mem_pop   = ~mem_empty & (~ovalid_q | out.ready);
  assign rel       = ovalid_q & out.ready;
  assign ovalid_d  = mem_pop ? 1'b1 : (rel ? 1'b0 : ovalid_q);
  assign odata_d   = mem_pop ? rd_data : odata_q;
  assign out.valid = ovalid_q;
  assign out.data  = odata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end
`else
  assign mem_pop   = ~mem_empty & out.ready;
  assign rel       = mem_pop;
  assign out.valid = ~mem_empty;
  assign out.data  = rd_data;
`endif

  assign wr_ptr_d = wr_ptr_q + PW'(accept);
  assign rd_ptr_d = rd_ptr_q + PW'(mem_pop);

  always_comb begin
    level_d = level_q;
    case ({accept, rel})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = mem_full;

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: DEPTH=16 main instance plus DEPTH=4 instance for wrap-around.
module tb_axis_fifo;

`ifdef AXIS_FIFO_OUTPUT_REG_EN
  localparam int OREG = 1;
`else
  localparam int OREG = 0;
`endif
  localparam int D_A   = 16;
  localparam int D_B   = 4;
  localparam int CAP_A = D_A + OREG;
  localparam int LW_A  = $clog2(D_A + 2);
  localparam int LW_B  = $clog2(D_B + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_if #(.data_t(logic [7:0])) a_in ();
  axis_if #(.data_t(logic [7:0])) a_out ();
  axis_if #(.data_t(logic [7:0])) b_in ();
  axis_if #(.data_t(logic [7:0])) b_out ();

  logic [LW_A-1:0] level_a;
  logic            empty_a, full_a;
  logic [LW_B-1:0] level_b;
  logic            empty_b, full_b;

  axis_fifo #(.DEPTH(D_A), .data_t(logic [7:0])) dut_a (
    .clk (clk), .rst (rst), .in (a_in), .out (a_out),
    .level (level_a), .empty (empty_a), .full (full_a)
  );

  axis_fifo #(.DEPTH(D_B), .data_t(logic [7:0])) dut_b (
    .clk (clk), .rst (rst), .in (b_in), .out (b_out),
    .level (level_b), .empty (empty_b), .full (full_b)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         checks = 0;
  int         errors = 0;
  int         n_acc_a = 0, n_rel_a = 0, n_acc_b = 0, n_rel_b = 0;
  logic [7:0] src_a = '0, src_b = '0;
  bit         hold_a = 1'b0;
  logic [7:0] hold_data_a = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src_a(input logic [7:0] v);
    src_a = v;
    a_in.data = v;
  endtask

  task automatic set_src_b(input logic [7:0] v);
    src_b = v;
    b_in.data = v;
  endtask

  // Called just after a negedge: resolve handshakes, advance one clock, update sources.
  task automatic tick();
    bit acc_a, rel_a, acc_b, rel_b;
    #1;
    acc_a = a_in.valid && a_in.ready;
    rel_a = a_out.valid && a_out.ready;
    acc_b = b_in.valid && b_in.ready;
    rel_b = b_out.valid && b_out.ready;
    if (hold_a) begin
      chk("a_hold_valid", a_out.valid, 1);
      chk("a_hold_data", a_out.data, hold_data_a);
    end
    hold_a = a_out.valid && !a_out.ready;
    hold_data_a = a_out.data;
    if (rel_a) begin
      n_rel_a++;
      if (exp_a.size() == 0) chk("a_extra_word", 0, 1);
      else chk("a_data", a_out.data, exp_a.pop_front());
    end
    if (acc_a) begin
      exp_a.push_back(a_in.data);
      n_acc_a++;
    end
    if (rel_b) begin
      n_rel_b++;
      if (exp_b.size() == 0) chk("b_extra_word", 0, 1);
      else chk("b_data", b_out.data, exp_b.pop_front());
    end
    if (acc_b) begin
      exp_b.push_back(b_in.data);
      n_acc_b++;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc_a) set_src_a(src_a + 8'd1);
    if (acc_b) set_src_b(src_b + 8'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", a_out.valid, 0);
    chk("rst_in_ready", a_in.ready, 0);
    chk("rst_level", level_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in.ready, 1);
    @(negedge clk);

    // Fill with consumer stalled; the extra word stays at the source
    set_src_a(8'd0);
    a_in.valid = 1'b1;
    a_out.ready = 1'b0;
    repeat (CAP_A + 4) tick();
    chk("fill_accepts", n_acc_a, CAP_A);
    chk("fill_full", full_a, 1);
    chk("fill_in_ready", a_in.ready, 0);
    chk("fill_level", level_a, CAP_A);
    chk("fill_held_word", a_in.data, CAP_A);

    // Drain in order
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    repeat (CAP_A + 3) tick();
    chk("drain_count", n_rel_a, CAP_A);
    chk("drain_empty", empty_a, 1);
    chk("drain_out_valid", a_out.valid, 0);
    chk("drain_level", level_a, 0);
    chk("drain_sb_empty", exp_a.size(), 0);

    // Streaming 0x00..0xFF, one word per cycle
    n_acc_a = 0; n_rel_a = 0;
    set_src_a(8'd0);
    a_in.valid = 1'b1;
    a_out.ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 1) chk("stream_lat_k1", a_out.valid, (OREG == 0) ? 1 : 0);
      if (k == 2) chk("stream_lat_k2", a_out.valid, 1);
      if (k >= 3) chk("stream_level", level_a, 1 + OREG);
    end
    a_in.valid = 1'b0;
    repeat (4) tick();
    chk("stream_accepts", n_acc_a, 256);
    chk("stream_releases", n_rel_a, 256);
    chk("stream_empty", empty_a, 1);

    // Random back-pressure, 1000 words
    n_acc_a = 0; n_rel_a = 0;
    cyc = 0;
    while (n_rel_a < 1000 && cyc < 8000) begin
      if (!(a_in.valid && !a_in.ready)) a_in.valid = ($urandom_range(0, 3) != 0);
      a_out.ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    chk("bp_reached_1000", (n_rel_a >= 1000) ? 1 : 0, 1);
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    repeat (CAP_A + 3) tick();
    chk("bp_no_drop_dup", n_rel_a, n_acc_a);
    chk("bp_sb_empty", exp_a.size(), 0);
    a_out.ready = 1'b0;

    // Wrap-around on DEPTH=4 at fill 3
    set_src_b(8'd0);
    b_in.valid = 1'b1;
    b_out.ready = 1'b0;
    repeat (3) tick();
    chk("wrap_fill_level", level_b, 3);
    b_out.ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("wrap_no_full", full_b, 0);
      chk("wrap_no_empty", empty_b, 0);
      chk("wrap_level", level_b, 3);
    end
    b_in.valid = 1'b0;
    repeat (6) tick();
    chk("wrap_releases", n_rel_b, 43);
    chk("wrap_empty", empty_b, 1);
    b_out.ready = 1'b0;

    // Mid-operation asynchronous reset at level 7
    set_src_a(8'h40);
    a_in.valid = 1'b1;
    a_out.ready = 1'b0;
    repeat (7) tick();
    chk("mid_level_before", level_a, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_out_valid", a_out.valid, 0);
    chk("mid_level", level_a, 0);
    chk("mid_empty", empty_a, 1);
    chk("mid_in_ready", a_in.ready, 0);
    exp_a.delete();
    exp_b.delete();
    hold_a = 1'b0;
    a_in.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_rel_a = 0;
    set_src_a(8'hA5);
    a_in.valid = 1'b1;
    tick();
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    repeat (4) tick();
    chk("mid_first_read_count", n_rel_a, 1);
    chk("mid_sb_empty", exp_a.size(), 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
